mem_writeback: RTL and testbench
================================

# mem_writeback

Final stage of core_v0; consumes the execute stage's result bundle. For loads and stores it runs a request/acknowledge transaction on the data-memory port with a bounded wait. It then retires each instruction by pulsing a register-file write, when needed, and publishing the next PC to fetch. It owns no architectural state beyond one latched instruction.

## Interface
- XLEN, 32, datapath and address width
- REG_AW, 5, register index width
- MEM_TIMEOUT, 16, max cycles waiting for dmem_ack (≥2)

- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- exe_op  in  8  opcode (0x33, 0x13, 0x03, 0x23, 0x6f, 0x63)
- exe_funct3  in  3  funct3
- exe_rd  in  REG_AW  destination register
- exe_rd_d  in  XLEN  ALU/link result
- exe_memw_d  in  XLEN  store data
- exe_addr  in  XLEN  word address for LW/SW
- exe_pc  in  XLEN  next PC from execute
- dmem_req / dmem_we  out  1  request / write enable
- dmem_addr, dmem_wdata  out  XLEN  address / store data
- dmem_ack  in  1  memory done
- dmem_rdata  in  XLEN  load data, valid with ack
- regfw_we  out  1  register write pulse
- regfw_rd  out  REG_AW  write index
- regfw_d  out  XLEN  write data
- pc_valid  out  1  retire pulse
- pc_out  out  XLEN  next PC
- err_timeout, err_illegal  out  1  one-cycle error pulses

## Operation
- States: IDLE, MEM, WB.
- in_ready = (state==IDLE). A transfer occurs on a clock edge where in_valid & in_ready are both 1; all exe_* fields are latched on that edge.
- Routing of an accepted instruction:
  - 0x33, 0x13, 0x6f: go to WB; write data = exe_rd_d.
  - 0x03 with funct3=2 (LW): go to MEM, read.
  - 0x23 with funct3=2 (SW): go to MEM, write of exe_memw_d.
  - 0x63: go to WB, no register write.
  - Any other op/funct3: go to WB, no register write, err_illegal pulse.
- MEM: dmem_req=1; dmem_we, dmem_addr and dmem_wdata stay stable until the ack edge. On ack, LW latches dmem_rdata as write data; both LW and SW then go to WB.
- Timeout: a cycle counter clears on entry to MEM and increments each MEM cycle without ack. When it reaches MEM_TIMEOUT-1 with no ack, drop the request, pulse err_timeout, go to WB with the register write suppressed. If ack arrives on the threshold cycle, ack wins.
- WB (one cycle): pc_valid=1, pc_out = latched exe_pc. regfw_we=1 only if a write is required and rd≠0. Next state IDLE.
- Writes to x0 are always suppressed; pc_valid still pulses.

## Timing
- All outputs except in_ready are registered. Reset value of every output is 0; in_ready is 0 during reset and 1 on the first cycle after.
- Non-memory instruction: accept at edge N; regfw_we and pc_valid are high in cycle N+1. Throughput: one instruction per 2 cycles.
- Memory instruction: dmem_req rises in cycle N+1 and falls the cycle after the ack edge. Retire pulse comes one cycle after the ack edge. Minimum latency is 3 cycles.
- Timeout: err_timeout and pc_valid are high in the same cycle; dmem_req is low in that cycle.
- Reset in any state: return to IDLE, drop dmem_req, clear the counter, discard the latched instruction. No retire pulse is produced.
- dmem_ack seen outside MEM is ignored.

## Structure
- core_pkg holds:
  - opcode constants OP_R=8'h33, OP_I=8'h13, OP_LOAD=8'h03, OP_STORE=8'h23, OP_JAL=8'h6f, OP_BRANCH=8'h63
  - FUNCT3_W=3'h2
  - the state enum
  - the packed execute-result struct that mirrors the exe_* ports
- One sub-module, mem_req_timer: counter with clear, enable and expired output, parameterised by MEM_TIMEOUT.

## Test plan
- ADD result exe_rd=5, exe_rd_d=0x1234, exe_pc=0x10 → cycle N+1: regfw_we=1, rd=5, d=0x1234, pc_out=0x10.
- LW addr=0x40, ack after 3 cycles with rdata=0xCAFE → dmem_req high 3 cycles, we=0; next cycle regfw_d=0xCAFE, pc_valid=1.
- SW addr=0x44, memw_d=0xBEEF, immediate ack → dmem_we=1, wdata=0xBEEF; regfw_we never 1; pc_valid one cycle later.
- LW with ack never asserted, MEM_TIMEOUT=4 → req drops after 4 cycles; err_timeout and pc_valid pulse together; no register write.
- ADDI to rd=0, then op=0x7f → no register write for either; err_illegal pulses on the second; pc_valid pulses twice.
- Reset asserted mid-MEM, then ack → all outputs 0, no retire pulse, in_ready=1 after reset releases.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared opcodes, FSM state, execute-result bundle and op classifier
// for the core_v0 pipeline.
`default_nettype none

package core_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [7:0] OP_R      = 8'h33;
  localparam logic [7:0] OP_I      = 8'h13;
  localparam logic [7:0] OP_LOAD   = 8'h03;
  localparam logic [7:0] OP_STORE  = 8'h23;
  localparam logic [7:0] OP_JAL    = 8'h6f;
  localparam logic [7:0] OP_BRANCH = 8'h63;

  localparam logic [2:0] FUNCT3_W = 3'h2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } wb_state_e;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_e;

  typedef struct packed {
    logic [7:0]            op;
    logic [2:0]            funct3;
    logic [REG_AW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   rd_d;
    logic [XLEN_DEF-1:0]   memw_d;
    logic [XLEN_DEF-1:0]   addr;
    logic [XLEN_DEF-1:0]   pc;
  } exe_result_t;

  // Only word-sized loads/stores are supported; other widths are illegal.
  function automatic op_class_e classify(input logic [7:0] op, input logic [2:0] funct3);
    op_class_e cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_R, OP_I, OP_JAL: cls = CLS_ALU;
      OP_LOAD:            cls = (funct3 == FUNCT3_W) ? CLS_LOAD : CLS_ILLEGAL;
      OP_STORE:           cls = (funct3 == FUNCT3_W) ? CLS_STORE : CLS_ILLEGAL;
      OP_BRANCH:          cls = CLS_BRANCH;
      default:            cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_req_timer.sv
// mem_req_timer: cycle counter for the data-memory wait, flags when the
// count reaches MEM_TIMEOUT-1.
`default_nettype none

module mem_req_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_writeback.sv
// mem_writeback: final core_v0 stage; runs the dmem transaction for LW/SW,
// then retires with a register-file write pulse and the next PC.
`default_nettype none

module mem_writeback
  import core_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        exe_op_i,
  input  logic [2:0]        exe_funct3_i,
  input  logic [REG_AW-1:0] exe_rd_i,
  input  logic [XLEN-1:0]   exe_rd_d_i,
  input  logic [XLEN-1:0]   exe_memw_d_i,
  input  logic [XLEN-1:0]   exe_addr_i,
  input  logic [XLEN-1:0]   exe_pc_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              regfw_we_o,
  output logic [REG_AW-1:0] regfw_rd_o,
  output logic [XLEN-1:0]   regfw_d_o,
  output logic              pc_valid_o,
  output logic [XLEN-1:0]   pc_out_o,
  output logic              err_timeout_o,
  output logic              err_illegal_o
);

  exe_result_t w_exe;
  op_class_e   w_cls;
  logic        w_accept;
  logic        w_expired;

  wb_state_e         state_q;
  logic [REG_AW-1:0] rd_q;
  logic [XLEN-1:0]   pc_q;
  logic              load_q;

  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [XLEN-1:0]   dmem_addr_q;
  logic [XLEN-1:0]   dmem_wdata_q;
  logic              regfw_we_q;
  logic [REG_AW-1:0] regfw_rd_q;
  logic [XLEN-1:0]   regfw_d_q;
  logic              pc_valid_q;
  logic [XLEN-1:0]   pc_out_q;
  logic              err_timeout_q;
  logic              err_illegal_q;

  assign w_exe = '{op: exe_op_i, funct3: exe_funct3_i, rd: exe_rd_i, rd_d: exe_rd_d_i,
                   memw_d: exe_memw_d_i, addr: exe_addr_i, pc: exe_pc_i};
  assign w_cls = classify(w_exe.op, w_exe.funct3);

  assign in_ready_o = (state_q == ST_IDLE) && !reset_i;
  assign w_accept   = in_ready_o && in_valid_i;

  mem_req_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (w_accept),
    .en_i      ((state_q == ST_MEM) && !dmem_ack_i),
    .expired_o (w_expired)
  );

  // Retire outputs are loaded on the edge that enters WB so they are high
  // exactly during the single WB cycle.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      rd_q          <= '0;
      pc_q          <= '0;
      load_q        <= 1'b0;
      dmem_req_q    <= 1'b0;
      dmem_we_q     <= 1'b0;
      dmem_addr_q   <= '0;
      dmem_wdata_q  <= '0;
      regfw_we_q    <= 1'b0;
      regfw_rd_q    <= '0;
      regfw_d_q     <= '0;
      pc_valid_q    <= 1'b0;
      pc_out_q      <= '0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
    end else begin
      regfw_we_q    <= 1'b0;
      pc_valid_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            rd_q   <= w_exe.rd;
            pc_q   <= w_exe.pc;
            load_q <= (w_cls == CLS_LOAD);
            if ((w_cls == CLS_LOAD) || (w_cls == CLS_STORE)) begin
              state_q      <= ST_MEM;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= (w_cls == CLS_STORE);
              dmem_addr_q  <= w_exe.addr;
              dmem_wdata_q <= w_exe.memw_d;
            end else begin
              state_q       <= ST_WB;
              pc_valid_q    <= 1'b1;
              pc_out_q      <= w_exe.pc;
              regfw_we_q    <= (w_cls == CLS_ALU) && (w_exe.rd != '0);
              regfw_rd_q    <= w_exe.rd;
              regfw_d_q     <= w_exe.rd_d;
              err_illegal_q <= (w_cls == CLS_ILLEGAL);
            end
          end
        end
        ST_MEM: begin
          // Ack takes priority over the timeout on the threshold cycle.
          if (dmem_ack_i || w_expired) begin
            state_q       <= ST_WB;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            pc_valid_q    <= 1'b1;
            pc_out_q      <= pc_q;
            regfw_rd_q    <= rd_q;
            regfw_d_q     <= dmem_rdata_i;
            regfw_we_q    <= dmem_ack_i && load_q && (rd_q != '0);
            err_timeout_q <= !dmem_ack_i;
          end
        end
        ST_WB: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem_req_o    = dmem_req_q;
  assign dmem_we_o     = dmem_we_q;
  assign dmem_addr_o   = dmem_addr_q;
  assign dmem_wdata_o  = dmem_wdata_q;
  assign regfw_we_o    = regfw_we_q;
  assign regfw_rd_o    = regfw_rd_q;
  assign regfw_d_o     = regfw_d_q;
  assign pc_valid_o    = pc_valid_q;
  assign pc_out_o      = pc_out_q;
  assign err_timeout_o = err_timeout_q;
  assign err_illegal_o = err_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_writeback.sv
// tb_mem_writeback: directed plus randomized instructions against a
// per-instruction timeline model of the writeback stage.
`default_nettype none

module tb_mem_writeback;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  exe_op;
  logic [2:0]  exe_funct3;
  logic [4:0]  exe_rd;
  logic [31:0] exe_rd_d;
  logic [31:0] exe_memw_d;
  logic [31:0] exe_addr;
  logic [31:0] exe_pc;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        regfw_we;
  logic [4:0]  regfw_rd;
  logic [31:0] regfw_d;
  logic        pc_valid;
  logic [31:0] pc_out;
  logic        err_timeout;
  logic        err_illegal;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  mem_writeback #(
    .XLEN        (32),
    .REG_AW      (5),
    .MEM_TIMEOUT (T)
  ) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .exe_op_i      (exe_op),
    .exe_funct3_i  (exe_funct3),
    .exe_rd_i      (exe_rd),
    .exe_rd_d_i    (exe_rd_d),
    .exe_memw_d_i  (exe_memw_d),
    .exe_addr_i    (exe_addr),
    .exe_pc_i      (exe_pc),
    .dmem_req_o    (dmem_req),
    .dmem_we_o     (dmem_we),
    .dmem_addr_o   (dmem_addr),
    .dmem_wdata_o  (dmem_wdata),
    .dmem_ack_i    (dmem_ack),
    .dmem_rdata_i  (dmem_rdata),
    .regfw_we_o    (regfw_we),
    .regfw_rd_o    (regfw_rd),
    .regfw_d_o     (regfw_d),
    .pc_valid_o    (pc_valid),
    .pc_out_o      (pc_out),
    .err_timeout_o (err_timeout),
    .err_illegal_o (err_illegal)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, " dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, " dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, " dmem_wdata"}, dmem_wdata, 32'd0);
    chk({tag, " regfw_we"}, 32'(regfw_we), 32'd0);
    chk({tag, " regfw_rd"}, 32'(regfw_rd), 32'd0);
    chk({tag, " regfw_d"}, regfw_d, 32'd0);
    chk({tag, " pc_valid"}, 32'(pc_valid), 32'd0);
    chk({tag, " pc_out"}, pc_out, 32'd0);
    chk({tag, " err_timeout"}, 32'(err_timeout), 32'd0);
    chk({tag, " err_illegal"}, 32'(err_illegal), 32'd0);
  endtask

  // Called at a falling edge while the stage is idle; returns at the falling
  // edge of the first idle cycle after retirement. ack_at is the 1-based MEM
  // cycle carrying the ack; 0 or beyond T means the ack never comes.
  task automatic txn(input logic [7:0] op, input logic [2:0] f3, input logic [4:0] rd,
                     input logic [31:0] rd_d, input logic [31:0] memw, input logic [31:0] addr,
                     input logic [31:0] pc, input logic [31:0] rdata, input int ack_at);
    bit          is_ld, is_st, is_mem, is_alu, illegal, tmo, writes;
    int          nreq;
    logic [31:0] exp_d;
    is_ld   = (op == 8'h03) && (f3 == 3'd2);
    is_st   = (op == 8'h23) && (f3 == 3'd2);
    is_mem  = is_ld || is_st;
    is_alu  = (op == 8'h33) || (op == 8'h13) || (op == 8'h6f);
    illegal = !(is_mem || is_alu || (op == 8'h63));
    tmo     = is_mem && !((ack_at >= 1) && (ack_at <= T));
    nreq    = !is_mem ? 0 : (tmo ? T : ack_at);
    writes  = (rd != 5'd0) && (is_alu || (is_ld && !tmo));
    exp_d   = is_ld ? rdata : rd_d;

    chk("in_ready idle", 32'(in_ready), 32'd1);
    exe_op     = op;
    exe_funct3 = f3;
    exe_rd     = rd;
    exe_rd_d   = rd_d;
    exe_memw_d = memw;
    exe_addr   = addr;
    exe_pc     = pc;
    in_valid   = 1'b1;
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    for (int c = 1; c <= nreq + 2; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
      exe_rd_d = $urandom;
      exe_pc   = $urandom;
      if (c <= nreq) begin
        chk("mem dmem_req", 32'(dmem_req), 32'd1);
        chk("mem dmem_we", 32'(dmem_we), 32'(is_st));
        chk("mem dmem_addr", dmem_addr, addr);
        if (is_st) chk("mem dmem_wdata", dmem_wdata, memw);
        chk("mem pc_valid", 32'(pc_valid), 32'd0);
        chk("mem regfw_we", 32'(regfw_we), 32'd0);
        chk("mem in_ready", 32'(in_ready), 32'd0);
        dmem_ack   = (c == ack_at);
        dmem_rdata = (c == ack_at) ? rdata : $urandom;
      end else if (c == nreq + 1) begin
        chk("wb pc_valid", 32'(pc_valid), 32'd1);
        chk("wb pc_out", pc_out, pc);
        chk("wb regfw_we", 32'(regfw_we), 32'(writes));
        if (writes) begin
          chk("wb regfw_rd", 32'(regfw_rd), 32'(rd));
          chk("wb regfw_d", regfw_d, exp_d);
        end
        chk("wb err_timeout", 32'(err_timeout), 32'(tmo));
        chk("wb err_illegal", 32'(err_illegal), 32'(illegal));
        chk("wb dmem_req", 32'(dmem_req), 32'd0);
        chk("wb in_ready", 32'(in_ready), 32'd0);
        dmem_ack = 1'($urandom_range(0, 1));
      end else begin
        chk("post pc_valid", 32'(pc_valid), 32'd0);
        chk("post regfw_we", 32'(regfw_we), 32'd0);
        chk("post dmem_req", 32'(dmem_req), 32'd0);
        chk("post err_timeout", 32'(err_timeout), 32'd0);
        chk("post err_illegal", 32'(err_illegal), 32'd0);
        chk("post in_ready", 32'(in_ready), 32'd1);
      end
    end
  endtask

  initial begin
    logic [7:0] ops [8];
    logic [7:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    ops[0] = 8'h33; ops[1] = 8'h13; ops[2] = 8'h03; ops[3] = 8'h23;
    ops[4] = 8'h6f; ops[5] = 8'h63; ops[6] = 8'h7f; ops[7] = 8'h00;

    reset      = 1'b1;
    in_valid   = 1'b0;
    exe_op     = '0;
    exe_funct3 = '0;
    exe_rd     = '0;
    exe_rd_d   = '0;
    exe_memw_d = '0;
    exe_addr   = '0;
    exe_pc     = '0;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(negedge clock);
    chk_quiet("reset");
    chk("reset in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("after reset in_ready", 32'(in_ready), 32'd1);

    txn(8'h33, 3'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h10, 32'h0, 0);       // ADD
    txn(8'h03, 3'd2, 5'd7, 32'h5555, 32'h0, 32'h40, 32'h14, 32'hCAFE, 3);   // LW, ack in 3rd cycle
    txn(8'h23, 3'd2, 5'd9, 32'h7777, 32'hBEEF, 32'h44, 32'h18, 32'h0, 1);   // SW, immediate ack
    txn(8'h03, 3'd2, 5'd3, 32'h0, 32'h0, 32'h48, 32'h1C, 32'h9999, 0);      // LW timeout
    txn(8'h13, 3'd0, 5'd0, 32'hABCD, 32'h0, 32'h0, 32'h20, 32'h0, 0);       // ADDI to x0
    txn(8'h7f, 3'd0, 5'd4, 32'hABCD, 32'h0, 32'h0, 32'h24, 32'h0, 0);       // illegal op
    txn(8'h03, 3'd2, 5'd6, 32'h0, 32'h0, 32'h4C, 32'h28, 32'h1357, T);      // ack on threshold
    txn(8'h03, 3'd1, 5'd6, 32'h42, 32'h0, 32'h50, 32'h2C, 32'h0, 1);        // LH: illegal
    txn(8'h63, 3'd0, 5'd8, 32'h42, 32'h0, 32'h0, 32'h30, 32'h0, 0);         // branch
    txn(8'h6f, 3'd0, 5'd1, 32'h34, 32'h0, 32'h0, 32'h80, 32'h0, 0);         // JAL link

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 7)];
      if (op == 8'h00) op = 8'($urandom);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd2;
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      txn(op, f3, rd, $urandom, $urandom, $urandom, $urandom, $urandom,
          int'($urandom_range(0, T + 2)));
    end

    // Reset in the middle of a memory wait, with an ack arriving during reset.
    exe_op = 8'h03; exe_funct3 = 3'd2; exe_rd = 5'd11; exe_addr = 32'h60; exe_pc = 32'h64;
    in_valid = 1'b1;
    dmem_ack = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    chk("rst-mid dmem_req", 32'(dmem_req), 32'd1);
    @(negedge clock);
    reset    = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hDEAD;
    repeat (2) begin
      @(negedge clock);
      chk_quiet("rst-mid");
      chk("rst-mid in_ready", 32'(in_ready), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    dmem_ack = 1'b0;
    chk("rst-rel in_ready", 32'(in_ready), 32'd1);
    repeat (3) begin
      @(negedge clock);
      chk_quiet("rst-rel");
      chk("rst-rel idle in_ready", 32'(in_ready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
